// File: rtl/enc_byte_decrypt_if.sv
// Stream, key and status signals of the byte decryptor.
// DEC_STATS_EN adds the byte_count status signal.
interface enc_byte_decrypt_if;
  logic [7:0]  key_in;
  logic        key_load;
  logic        key_valid;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
`ifdef DEC_STATS_EN
  logic [15:0] byte_count;

  modport master (
    output key_in, key_load, in_valid, in_data, out_ready,
    input  key_valid, in_ready, out_valid, out_data, busy, byte_count
  );
  modport slave (
    input  key_in, key_load, in_valid, in_data, out_ready,
    output key_valid, in_ready, out_valid, out_data, busy, byte_count
  );
`else
  modport master (
    output key_in, key_load, in_valid, in_data, out_ready,
    input  key_valid, in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  key_in, key_load, in_valid, in_data, out_ready,
    output key_valid, in_ready, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/enc_byte_decrypt.sv
// Byte decryptor: 2-stage pipeline into an output FIFO, key changes serialised by an FSM.
// Optional DEC_STATS_EN adds a saturating output byte counter cleared on key application.
module enc_byte_decrypt #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  enc_byte_decrypt_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StNoKey, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [7:0]      pend_q, pend_d;
  logic            key_valid_q, key_valid_d;
  logic            key_apply;

  logic            s1_vld_q;
  logic [7:0]      s1_data_q;
  logic            s2_vld_q;
  logic [7:0]      s2_data_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] inflight;
  logic [CntW:0]   occupancy;

  logic            accept, push, pop, out_valid;

  function automatic logic [7:0] decrypt(input logic [7:0] d, input logic [7:0] k);
    logic [3:0] lo;
    logic [7:0] e;
    logic [7:0] x;
    logic [3:0] s;
    lo = d[3:0];
    e  = {lo[3], lo[0], lo[1], lo[2], lo[1], lo[3], lo[2], lo[0]};
    x  = e ^ k;
    s  = x[7:4] + x[3:0] + {3'b000, k[0]};
    return {d[7:4] ^ s, lo};
  endfunction

  assign inflight  = CntW'(s1_vld_q) + CntW'(s2_vld_q);
  // Counting in-flight bytes against free slots means a push never meets a full FIFO.
  assign occupancy = (CntW + 1)'(cnt_q) + (CntW + 1)'(inflight);
  assign out_valid = (cnt_q != '0);

  assign bus.in_ready  = (state_q == StRun) && !bus.key_load &&
                         (occupancy < (CntW + 1)'(FIFO_DEPTH));
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.key_valid = key_valid_q;
  assign bus.busy      = (inflight != '0) || out_valid || (state_q == StDrain);

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = s2_vld_q;
  assign pop    = out_valid && bus.out_ready;
  assign cnt_d  = cnt_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    pend_d      = pend_q;
    key_valid_d = key_valid_q;
    key_apply   = 1'b0;
    case (state_q)
      StNoKey: begin
        if (bus.key_load) begin
          key_d       = bus.key_in;
          key_valid_d = 1'b1;
          key_apply   = 1'b1;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (bus.key_load) begin
          pend_d  = bus.key_in;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // A late reload replaces the pending key and keeps draining one more cycle.
        if (bus.key_load) begin
          pend_d = bus.key_in;
        end else if (inflight == '0 && cnt_q == '0) begin
          key_d     = pend_q;
          key_apply = 1'b1;
          state_d   = StRun;
        end
      end
      default: state_d = StNoKey;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StNoKey;
      key_q       <= 8'h00;
      pend_q      <= 8'h00;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      pend_q      <= pend_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= 8'h00;
      s2_vld_q  <= 1'b0;
      s2_data_q <= 8'h00;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_data_q <= bus.in_data;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_data_q <= decrypt(s1_data_q, key_q);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s2_data_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef DEC_STATS_EN
  logic [15:0] byte_count_q, byte_count_d;

  always_comb begin
    byte_count_d = byte_count_q;
    if (key_apply) begin
      byte_count_d = 16'h0000;
    end else if (pop && byte_count_q != 16'hFFFF) begin
      byte_count_d = byte_count_q + 16'h0001;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count_q <= 16'h0000;
    end else begin
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.byte_count = byte_count_q;
`endif

endmodule
